// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM transmit/decode pair.
package pdm_pkg;

  localparam int FRAME_BITS = 14;
  localparam int DATA_W     = 16;

  // The decoder integrates PDM ones over one frame, so a full-scale sample
  // decodes to roughly sample >> DEC_SHIFT.
  localparam int DEC_WINDOW = 1 << FRAME_BITS;
  localparam int DEC_SHIFT  = DATA_W - FRAME_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pdm_tx_if.sv
// Sample handshake and PDM output bundle between a sample source and pdm_tx.
interface pdm_tx_if #(
  parameter int DATA_W = pdm_pkg::DATA_W
) ();

  logic              en;
  logic              smpl_vld;
  logic [DATA_W-1:0] lft_smpl;
  logic [DATA_W-1:0] rght_smpl;
  logic              smpl_rdy;
  logic              lft_PDM;
  logic              rght_PDM;
  logic              frame_strt;
  logic              underrun;

  modport master (
    output en, smpl_vld, lft_smpl, rght_smpl,
    input  smpl_rdy, lft_PDM, rght_PDM, frame_strt, underrun
  );

  modport slave (
    input  en, smpl_vld, lft_smpl, rght_smpl,
    output smpl_rdy, lft_PDM, rght_PDM, frame_strt, underrun
  );

endinterface

// File: rtl/pdm_mod_ch.sv
// One channel of a first-order sigma-delta modulator: the accumulator carry
// is the PDM bit. The accumulator is never cleared at frame boundaries so the
// residue keeps the long-term density exact.
module pdm_mod_ch #(
  parameter int DATA_W = pdm_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] inc_i,
  output logic              pdm_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              pdm_q, pdm_d;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_i};

  // Clear has priority; otherwise accumulate while running
  always_comb begin
    acc_d = acc_q;
    pdm_d = pdm_q;
    if (clr_i) begin
      acc_d = '0;
      pdm_d = 1'b0;
    end else if (en_i) begin
      acc_d = sum[DATA_W-1:0];
      pdm_d = sum[DATA_W];
    end
  end

  // Accumulator and PDM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_o = pdm_q;

endmodule

// File: rtl/pdm_tx.sv
// Stereo PDM transmitter: double-buffered sample intake, frame timer and
// run/idle control around two modulator channels.
//
//   state | meaning
//   IDLE  | timer, accumulators and PDM held at 0; entry edge loads a frame
//   RUN   | modulating; boundary every 2^FRAME_BITS clocks
module pdm_tx #(
  parameter int FRAME_BITS = pdm_pkg::FRAME_BITS,
  parameter int DATA_W     = pdm_pkg::DATA_W
) (
  input logic     clk,
  input logic     rst,
  pdm_tx_if.slave bus
);
  import pdm_pkg::*;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] timer_q, timer_d;
  logic [DATA_W-1:0]     pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [DATA_W-1:0]     act_l_q, act_l_d, act_r_q, act_r_d;
  logic                  full_q, full_d;
  logic                  fs_q, fs_d;
  logic                  ur_q, ur_d;
  logic                  accept, entry, run, boundary;

  assign accept   = bus.smpl_vld & ~full_q;
  assign entry    = (state_q == IDLE) & bus.en;
  assign run      = (state_q == RUN) & bus.en;
  assign boundary = entry | (run & (timer_q == '1));

  // Next state and frame timer; dropping en leaves RUN on the same edge
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      IDLE: if (bus.en) state_d = RUN;
      RUN: begin
        if (bus.en) timer_d = timer_q + 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer handoff at boundaries, sample intake and boundary pulses
  always_comb begin
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    act_l_d  = act_l_q;
    act_r_d  = act_r_q;
    full_d   = full_q;
    fs_d     = boundary;
    ur_d     = boundary & ~full_q & ~entry;
    if (boundary && full_q) begin
      act_l_d = pend_l_q;
      act_r_d = pend_r_q;
      full_d  = 1'b0;
    end
    // An accept on an empty boundary only fills pending; no bypass to active
    if (accept) begin
      pend_l_d = bus.lft_smpl;
      pend_r_d = bus.rght_smpl;
      full_d   = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Timer, sample buffers and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      pend_l_q <= '0;
      pend_r_q <= '0;
      act_l_q  <= '0;
      act_r_q  <= '0;
      full_q   <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      act_l_q  <= act_l_d;
      act_r_q  <= act_r_d;
      full_q   <= full_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end

  pdm_mod_ch #(.DATA_W(DATA_W)) u_lft (
    .clk   (clk),
    .rst   (rst),
    .en_i  (run),
    .clr_i (~run),
    .inc_i (act_l_q),
    .pdm_o (bus.lft_PDM)
  );

  pdm_mod_ch #(.DATA_W(DATA_W)) u_rght (
    .clk   (clk),
    .rst   (rst),
    .en_i  (run),
    .clr_i (~run),
    .inc_i (act_r_q),
    .pdm_o (bus.rght_PDM)
  );

  assign bus.smpl_rdy   = ~full_q;
  assign bus.frame_strt = fs_q;
  assign bus.underrun   = ur_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Scoreboard bench for pdm_tx with a short frame (FB=8, 256 clocks).
// Stimulus pushes per-boundary underrun expectations and per-frame ones-count
// windows; the monitor pops them on every frame_strt pulse.
module tb_pdm_tx;

  localparam int FB = 8;
  localparam int N  = 1 << FB;
  localparam int DW = 16;

  typedef struct {
    int lo_l;
    int hi_l;
    int lo_r;
    int hi_r;
  } frame_exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pdm_tx_if #(.DATA_W(DW)) bus ();

  pdm_tx #(.FRAME_BITS(FB), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_exp_t frame_q[$];
  bit         bnd_q[$];
  int         checks = 0;
  int         errors = 0;

  // Hand-computed ones per 256-clock frame
  localparam frame_exp_t EXP_A = '{0, 0, 128, 128};     // 0x0000 / 0x8000
  localparam frame_exp_t EXP_B = '{255, 256, 0, 1};     // 0xFFFF / 0x0001
  localparam frame_exp_t EXP_C = '{64, 64, 192, 192};   // 0x4000 / 0xC000

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: counts PDM ones between frame_strt pulses and checks them
  int cnt_l, cnt_r, cyc, last_fs;
  bit in_frame;
  initial begin
    cnt_l = 0; cnt_r = 0; cyc = 0; last_fs = 0; in_frame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst || !bus.en) begin
        in_frame = 1'b0;
      end else begin
        if (in_frame) begin
          cnt_l += int'(bus.lft_PDM);
          cnt_r += int'(bus.rght_PDM);
        end
        if (bus.frame_strt) begin
          if (bnd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_boundary: got frame_strt at cycle %0d expected none", cyc);
          end else begin
            bit e_ur;
            e_ur = bnd_q.pop_front();
            chk("underrun_at_boundary", int'(bus.underrun), int'(e_ur));
          end
          if (in_frame) begin
            chk("frame_period", cyc - last_fs, N);
            if (frame_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_frame: got frame end at cycle %0d expected none", cyc);
            end else begin
              frame_exp_t e;
              e = frame_q.pop_front();
              chk_rng("ones_left", cnt_l, e.lo_l, e.hi_l);
              chk_rng("ones_right", cnt_r, e.lo_r, e.hi_r);
            end
          end
          in_frame = 1'b1;
          cnt_l    = 0;
          cnt_r    = 0;
          last_fs  = cyc;
        end else if (bus.underrun) begin
          errors++;
          $display("FAIL underrun_no_frame: got underrun=1 expected 0 at cycle %0d", cyc);
        end
      end
    end
  end

  // Offer a pair from a negedge and hold it until accepted
  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int w;
    bus.smpl_vld  = 1'b1;
    bus.lft_smpl  = l;
    bus.rght_smpl = r;
    w = 0;
    while (!bus.smpl_rdy && w < 3 * N) begin
      @(negedge clk);
      w++;
    end
    if (!bus.smpl_rdy) begin
      errors++;
      $display("FAIL accept_timeout: got smpl_rdy=0 for %0d cycles expected 1", w);
      bus.smpl_vld = 1'b0;
    end else begin
      @(negedge clk);
      bus.smpl_vld = 1'b0;
      chk("rdy_low_after_accept", int'(bus.smpl_rdy), 0);
    end
  endtask

  task automatic wait_drain(input int limit);
    int i;
    i = 0;
    while ((bnd_q.size() != 0 || frame_q.size() != 0) && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (bnd_q.size() != 0 || frame_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d boundaries %0d frames pending expected 0",
               bnd_q.size(), frame_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int bad, ones_l, ones_r, fs_seen;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.smpl_vld  = 1'b0;
    bus.lft_smpl  = '0;
    bus.rght_smpl = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", int'(bus.smpl_rdy), 1);
    chk("reset_pdm", int'({bus.lft_PDM, bus.rght_PDM}), 0);
    chk("reset_frame_strt", int'(bus.frame_strt), 0);
    chk("reset_underrun", int'(bus.underrun), 0);
    rst = 1'b0;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.lft_PDM || bus.rght_PDM || bus.frame_strt || bus.underrun) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Entry loads A; B and C follow under backpressure; then two underruns
    bnd_q.push_back(1'b0);
    bnd_q.push_back(1'b0);
    bnd_q.push_back(1'b0);
    bnd_q.push_back(1'b1);
    bnd_q.push_back(1'b1);
    frame_q.push_back(EXP_A);
    frame_q.push_back(EXP_B);
    frame_q.push_back(EXP_C);
    frame_q.push_back(EXP_C);
    send_pair(16'h0000, 16'h8000);
    bus.en = 1'b1;
    send_pair(16'hFFFF, 16'h0001);
    send_pair(16'h4000, 16'hC000);
    wait_drain(6 * N);

    // Drop en mid-frame: PDM clears on the next edge and no boundary fires
    repeat (100) @(negedge clk);
    bus.en = 1'b0;
    ones_l = 0; ones_r = 0; fs_seen = 0;
    repeat (8) begin
      @(negedge clk);
      ones_l += int'(bus.lft_PDM);
      ones_r += int'(bus.rght_PDM);
      fs_seen += int'(bus.frame_strt | bus.underrun);
    end
    chk("disable_ones_left", ones_l, 0);
    chk("disable_ones_right", ones_r, 0);
    chk("disable_pulses", fs_seen, 0);
    chk("disable_rdy", int'(bus.smpl_rdy), 1);

    // Re-entry with nothing pending keeps C active and does not underrun
    bnd_q.push_back(1'b0);
    bnd_q.push_back(1'b1);
    frame_q.push_back(EXP_C);
    bus.en = 1'b1;
    wait_drain(3 * N);

    // Reset mid-operation discards the pending pair
    send_pair(16'h1234, 16'h5678);
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b0;
    #1;
    chk("midrst_rdy", int'(bus.smpl_rdy), 1);
    chk("midrst_pdm", int'({bus.lft_PDM, bus.rght_PDM}), 0);
    chk("midrst_pulses", int'({bus.frame_strt, bus.underrun}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
